fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main/ALU decoder.
- Owns the program counter, issues word requests to instruction memory over a req/ready + rvalid handshake, and holds the returned instruction stable for one execute window.
- Presents op, funct3 and funct7 to the decoder.
- Consumes the decoder's PCSrc and the datapath's branch/jump target to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word-aligned.
- NOP_INSTR, 32'h0000_0013, instruction register content after reset (addi x0,x0,0).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address; equals pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  fetched instruction.
- PCSrc  in  1  1 = take PCTarget, 0 = sequential.
- PCTarget  in  32  branch/jal target from the datapath adder.
- stall  in  1  datapath not ready to retire the held instruction.
- instr_valid  out  1  instr/op/funct fields are valid for execute.
- instr  out  32  held instruction.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4; feeds the jal link write-back.
- misalign  out  1  sticky: a target with non-zero [1:0] was taken.
- retired  out  32  count of retired instructions.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronously):
  - state = REQ, pc = RESET_PC, instr = NOP_INSTR.
  - instr_valid = 0, misalign = 0, retired = 0.
  - imem_req is 1 once rst_n is released.
- op, funct3 and funct7 are pure slices of instr.
- pc_plus4 is combinational pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- imem_addr = pc at all times.
- State REQ:
  - imem_req = 1, instr_valid = 0.
  - imem_ready = 1 goes to WAIT next cycle; imem_ready = 0 stays in REQ.
  - imem_rvalid is ignored in REQ.
- State WAIT:
  - imem_req = 0.
  - imem_rvalid = 1 loads instr <= imem_rdata and goes to HOLD.
  - imem_rvalid = 0 stays in WAIT with no timeout.
- State HOLD:
  - instr_valid = 1; instr and pc are held constant.
  - stall = 1 stays in HOLD. The decoder may re-evaluate PCSrc each cycle; only the value at release counts.
  - stall = 0 sets pc <= PCSrc ? {PCTarget[31:2],2'b00} : pc_plus4, increments retired (wraps at 2^32), and goes to REQ.
- Misalignment: if PCSrc = 1 and PCTarget[1:0] != 0 at release, misalign <= 1. It stays 1 until reset. The PC is still updated with the low bits cleared.
- Minimum throughput is 3 cycles per instruction (REQ with ready, WAIT with rvalid next cycle, HOLD with stall = 0).
- Reset mid-fetch (in WAIT or HOLD) abandons the transaction. The instruction memory shares rst_n, so no stale response can arrive afterwards.
- imem_ready arriving in WAIT or HOLD is ignored.
- A stall asserted outside HOLD has no effect.

Test Plan:
1. Release rst_n with RESET_PC = 0, memory returns 32'h0050_0093 one cycle after ready → imem_addr = 0; instr_valid rises in cycle 3; op = 7'h13, funct3 = 0, funct7 = 0; pc_plus4 = 4. With stall = 0, next imem_addr = 4 and retired = 1.
2. Held instruction is a beq (32'h0020_8463), PCSrc = 1, PCTarget = 32'h0000_0040, stall = 0 → next fetch address is 0x40 and misalign stays 0.
3. Hold stall = 1 for 5 cycles in HOLD while PCSrc toggles, release with PCSrc = 0 → instr and pc are stable throughout; next address is pc + 4; retired increments by exactly 1.
4. imem_ready = 0 for 4 cycles, then rvalid delayed 3 cycles → imem_req stays high until ready; no instr_valid before rvalid; the instruction is captured exactly once.
5. PCSrc = 1 with PCTarget = 32'h0000_0106 → pc = 32'h0000_0104 and misalign = 1, which persists through later fetches until rst_n.
6. Assert rst_n low during WAIT at pc = 0x20 → outputs return to reset values immediately; after release the fetch restarts at RESET_PC and retired = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly in front of the main/ALU decoder.
// It owns the program counter and requests one word at a time from
// instruction memory. Each instruction moves through three phases:
//   REQ  - request the word at pc until memory accepts it (imem_ready)
//   WAIT - wait for the read data (imem_rvalid), however long it takes
//   HOLD - keep the instruction stable for execute until the datapath
//          releases it (stall low); then pick the next pc
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   imem_req          request strobe, high while in REQ
//   imem_addr         fetch address, always equal to pc
//   imem_ready        memory accepted the request this cycle
//   imem_rvalid       imem_rdata carries the fetched word
//   imem_rdata        fetched instruction word
//   PCSrc, PCTarget   next-pc select and branch/jal target (sampled at release)
//   stall             datapath not ready to retire the held instruction
//   instr_valid       instr/op/funct3/funct7 are valid for execute
//   instr             held instruction
//   op/funct3/funct7  decoder fields sliced from instr
//   pc, pc_plus4      address of the held instruction and its successor
//   misalign          sticky flag: a target with non-zero [1:0] was taken
//   retired           count of retired instructions (wraps)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // The held instruction retires when execute stops stalling.
    logic release_instr;

    // Targets are forced to word alignment; the dropped bits only feed misalign.
    logic [31:0] aligned_target;

    assign release_instr  = (state == HOLD) && !stall;
    assign aligned_target = {PCTarget[31:2], 2'b00};

    assign op        = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[30];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= REQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            REQ: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    next_state = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    next_state = REQ;
                end
            end
            default: begin
                next_state = REQ;
            end
        endcase
    end

    // Instruction capture happens only on the single rvalid beat in WAIT, so
    // stray rvalid in REQ or HOLD can never overwrite the held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
        end else if ((state == WAIT) && imem_rvalid) begin
            instr <= imem_rdata;
        end
    end

    // PC, retire counter and misalign flag only move at release; PCSrc and
    // PCTarget are free to change during a stall without consequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            retired  <= 32'd0;
            misalign <= 1'b0;
        end else if (release_instr) begin
            pc      <= PCSrc ? aligned_target : pc_plus4;
            retired <= retired + 32'd1;
            if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A transaction-level model keeps the
// expected pc, retired count and misalign flag; each fetch is driven through
// its REQ / WAIT / HOLD phases with chosen or random delays, and outputs are
// compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_retired;
    logic        exp_mis;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign    (misalign),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        exp_pc      = RESET_PC;
        exp_retired = 32'd0;
        exp_mis     = 1'b0;
    endtask

    task automatic quiet_inputs();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        PCSrc       = 1'b0;
        PCTarget    = 32'd0;
        stall       = 1'b0;
    endtask

    // Immediate reset values, checked while rst_n is low.
    task automatic check_reset_values(input string tag);
        n_checks++;
        if (pc !== RESET_PC || imem_addr !== RESET_PC) begin
            n_fail++;
            $display("[TB] FAIL %s_pc: pc=%h addr=%h, required %h", tag, pc, imem_addr, RESET_PC);
        end
        n_checks++;
        if (instr !== NOP_INSTR) begin
            n_fail++;
            $display("[TB] FAIL %s_instr: got %h, required %h", tag, instr, NOP_INSTR);
        end
        n_checks++;
        if ({instr_valid, misalign} !== 2'b00 || retired !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL %s_flags: valid=%b misalign=%b retired=%0d, required 0 0 0",
                     tag, instr_valid, misalign, retired);
        end
    endtask

    // One complete fetch. Entered and left on a falling edge with the DUT
    // expected in REQ. Ready is withheld ready_delay cycles, rvalid is
    // withheld rvalid_delay cycles, and the instruction is stalled
    // stall_cycles cycles before release with (take, target).
    task automatic fetch_one(input int ready_delay, input int rvalid_delay,
                             input int stall_cycles, input logic take,
                             input logic [31:0] target, input logic [31:0] data);
        for (int i = 0; i <= ready_delay; i++) begin
            n_checks++;
            if ({imem_req, instr_valid} !== 2'b10 || imem_addr !== exp_pc) begin
                n_fail++;
                $display("[TB] FAIL req_phase: req=%b valid=%b addr=%h, required req=1 valid=0 addr=%h",
                         imem_req, instr_valid, imem_addr, exp_pc);
            end
            imem_ready  = (i == ready_delay);
            imem_rvalid = 1'($urandom_range(1, 0));
            imem_rdata  = $urandom;
            stall       = 1'($urandom_range(1, 0));
            PCSrc       = 1'($urandom_range(1, 0));
            PCTarget    = $urandom;
            @(negedge clk);
        end
        for (int j = 0; j <= rvalid_delay; j++) begin
            n_checks++;
            if ({imem_req, instr_valid} !== 2'b00 || imem_addr !== exp_pc) begin
                n_fail++;
                $display("[TB] FAIL wait_phase: req=%b valid=%b addr=%h, required req=0 valid=0 addr=%h",
                         imem_req, instr_valid, imem_addr, exp_pc);
            end
            imem_rvalid = (j == rvalid_delay);
            imem_rdata  = (j == rvalid_delay) ? data : $urandom;
            imem_ready  = 1'($urandom_range(1, 0));
            stall       = 1'($urandom_range(1, 0));
            PCSrc       = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        for (int k = 0; k <= stall_cycles; k++) begin
            n_checks++;
            if ({imem_req, instr_valid} !== 2'b01) begin
                n_fail++;
                $display("[TB] FAIL hold_valid: req=%b valid=%b, required req=0 valid=1",
                         imem_req, instr_valid);
            end
            n_checks++;
            if (instr !== data) begin
                n_fail++;
                $display("[TB] FAIL hold_instr: got %h, required %h", instr, data);
            end
            n_checks++;
            if ({op, funct3, funct7} !== {data[6:0], data[14:12], data[30]}) begin
                n_fail++;
                $display("[TB] FAIL hold_fields: op=%h f3=%h f7=%b, required op=%h f3=%h f7=%b",
                         op, funct3, funct7, data[6:0], data[14:12], data[30]);
            end
            n_checks++;
            if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
                n_fail++;
                $display("[TB] FAIL hold_pc: pc=%h pc_plus4=%h, required %h %h",
                         pc, pc_plus4, exp_pc, exp_pc + 32'd4);
            end
            n_checks++;
            if (retired !== exp_retired || misalign !== exp_mis) begin
                n_fail++;
                $display("[TB] FAIL hold_status: retired=%0d misalign=%b, required %0d %b",
                         retired, misalign, exp_retired, exp_mis);
            end
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            imem_ready  = 1'($urandom_range(1, 0));
            stall       = (k < stall_cycles);
            PCSrc       = (k < stall_cycles) ? 1'($urandom_range(1, 0)) : take;
            PCTarget    = (k < stall_cycles) ? $urandom : target;
            @(negedge clk);
        end
        if (take) begin
            if (target[1:0] != 2'b00) exp_mis = 1'b1;
            exp_pc = target & 32'hFFFF_FFFC;
        end else begin
            exp_pc = exp_pc + 32'd4;
        end
        exp_retired = exp_retired + 32'd1;
        quiet_inputs();
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        quiet_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        $display("[TB] test_basic");
        fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h0050_0093);
        n_checks++;
        if (imem_addr !== 32'd4 || retired !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL basic_next: addr=%h retired=%0d, required 4 1", imem_addr, retired);
        end
    endtask

    task automatic test_branch();
        $display("[TB] test_branch");
        fetch_one(0, 0, 0, 1'b1, 32'h0000_0040, 32'h0020_8463);
        n_checks++;
        if (imem_addr !== 32'h40 || misalign !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL branch_next: addr=%h misalign=%b, required 40 0", imem_addr, misalign);
        end
    endtask

    task automatic test_stall();
        $display("[TB] test_stall");
        fetch_one(0, 0, 5, 1'b0, $urandom, $urandom);
    endtask

    task automatic test_delays();
        $display("[TB] test_delays");
        fetch_one(4, 3, 0, 1'b0, 32'd0, $urandom);
    endtask

    task automatic test_misalign();
        $display("[TB] test_misalign");
        fetch_one(0, 0, 0, 1'b1, 32'h0000_0106, $urandom);
        n_checks++;
        if (pc !== 32'h0000_0104 || misalign !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL misalign_taken: pc=%h misalign=%b, required 104 1", pc, misalign);
        end
        fetch_one(1, 1, 1, 1'b0, 32'd0, $urandom);
        fetch_one(0, 2, 0, 1'b1, 32'h0000_0200, $urandom);
    endtask

    task automatic test_wrap();
        $display("[TB] test_wrap");
        fetch_one(0, 0, 0, 1'b1, 32'hFFFF_FFFC, $urandom);
        fetch_one(0, 0, 0, 1'b0, 32'd0, $urandom);
        n_checks++;
        if (imem_addr !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL wrap_addr: got %h, required 0", imem_addr);
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        for (int n = 0; n < 25; n++) begin
            fetch_one($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                      1'($urandom_range(1, 0)), $urandom, $urandom);
        end
    endtask

    task automatic test_reset_midfetch();
        $display("[TB] test_reset_midfetch");
        fetch_one(0, 0, 0, 1'b1, 32'h0000_0020, $urandom);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midfetch_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fetch_one(0, 1, 0, 1'b0, 32'd0, $urandom);
        n_checks++;
        if (imem_addr !== RESET_PC + 32'd4 || retired !== 32'd1) begin
            n_fail++;
            $display("[TB] FAIL midfetch_restart: addr=%h retired=%0d, required %h 1",
                     imem_addr, retired, RESET_PC + 32'd4);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_stall();
        test_delays();
        test_misalign();
        test_wrap();
        test_random();
        test_reset_midfetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
